// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
// Holds the FSM state encoding and the fault cause codes reported on
// fault_cause, so that the sequencer and anything decoding its status
// agree on one set of values.
package instruction_fetch_pkg;

   typedef enum logic [2:0] {
      S_START = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_EXEC  = 3'd3,
      S_FAULT = 3'd4
   } fetchState_t;

   localparam logic [1:0] FAULT_NONE     = 2'b00;
   localparam logic [1:0] FAULT_MISALIGN = 2'b01;
   localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch sequencer sitting between the program counter and instruction memory.
// It reads the word at pc_current over a req/ack port, holds it for the core
// until exec_done, then strobes update_pc so the PC advances. A misaligned next
// PC or a memory that never acknowledges latches a sticky fault and halts.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   pc_current          PC value presented by program_counter
//   pc_next_valid       PC's next address is word-aligned
//   exec_done           core has finished the held instruction
//   update_pc           one-cycle PC load strobe
//   mem_req/mem_addr    instruction read request and address
//   mem_ack/mem_rdata   read acknowledge and data
//   instr/instr_pc      fetched instruction and its address
//   instr_valid         instr/instr_pc are valid for decode
//   fault/fault_cause   sticky fault flag and first cause
//   fetch_count         number of completed fetches (wraps)
module instruction_fetch #(
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_WIDTH      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] pc_current,
   input  logic                  pc_next_valid,
   input  logic                  exec_done,
   output logic                  update_pc,
   output logic                  mem_req,
   output logic [DATA_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [DATA_WIDTH-1:0] instr_pc,
   output logic                  instr_valid,
   output logic                  fault,
   output logic [1:0]            fault_cause,
   output logic [31:0]           fetch_count
);

   import instruction_fetch_pkg::*;

   localparam logic [CNT_WIDTH-1:0] LAST_WAIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   fetchState_t            r_state;
   fetchState_t            w_nextState;
   logic [DATA_WIDTH-1:0]  r_reqAddr;
   logic [CNT_WIDTH-1:0]   r_waitCount;
   logic [DATA_WIDTH-1:0]  r_instr;
   logic [DATA_WIDTH-1:0]  r_instrPc;
   logic                   r_instrValid;
   logic                   r_fault;
   logic [1:0]             r_faultCause;
   logic [31:0]            r_fetchCount;

   logic                   w_capture;
   logic                   w_setFault;
   logic [1:0]             w_faultCode;
   logic                   w_memReq;
   logic [DATA_WIDTH-1:0]  w_memAddr;
   logic                   w_updatePc;

   // Next-state and request decode. The address is taken live from the PC in
   // the first request cycle and from the latched copy while waiting, so the
   // memory sees a stable address for the whole transaction. An ack in the
   // final wait cycle is checked before the timeout so a late ack still wins.
   always_comb begin
      w_nextState = r_state;
      w_capture   = 1'b0;
      w_setFault  = 1'b0;
      w_faultCode = FAULT_NONE;
      w_memReq    = 1'b0;
      w_memAddr   = '0;
      w_updatePc  = 1'b0;
      case (r_state)
         S_START: begin
            w_nextState = S_REQ;
         end
         S_REQ: begin
            w_memReq  = 1'b1;
            w_memAddr = pc_current;
            if (mem_ack) begin
               w_capture   = 1'b1;
               w_nextState = S_EXEC;
            end else begin
               w_nextState = S_WAIT;
            end
         end
         S_WAIT: begin
            w_memReq  = 1'b1;
            w_memAddr = r_reqAddr;
            if (mem_ack) begin
               w_capture   = 1'b1;
               w_nextState = S_EXEC;
            end else if (r_waitCount == LAST_WAIT) begin
               w_setFault  = 1'b1;
               w_faultCode = FAULT_TIMEOUT;
               w_nextState = S_FAULT;
            end
         end
         S_EXEC: begin
            if (exec_done) begin
               if (pc_next_valid) begin
                  w_updatePc  = 1'b1;
                  w_nextState = S_REQ;
               end else begin
                  w_setFault  = 1'b1;
                  w_faultCode = FAULT_MISALIGN;
                  w_nextState = S_FAULT;
               end
            end
         end
         S_FAULT: begin
            w_nextState = S_FAULT;
         end
         default: begin
            w_nextState = S_START;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_START;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Request address latch and wait counter. The counter restarts on every
   // new request and counts the cycles spent waiting for the ack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_reqAddr   <= '0;
         r_waitCount <= '0;
      end else begin
         if (r_state == S_REQ) begin
            r_reqAddr   <= pc_current;
            r_waitCount <= '0;
         end else if (r_state == S_WAIT) begin
            r_waitCount <= r_waitCount + 1'b1;
         end
      end
   end

   // Instruction capture. instr_valid follows the state we are entering, so it
   // rises on the edge after the capture and drops as soon as we leave S_EXEC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instr      <= '0;
         r_instrPc    <= '0;
         r_instrValid <= 1'b0;
         r_fetchCount <= '0;
      end else begin
         r_instrValid <= (w_nextState == S_EXEC);
         if (w_capture) begin
            r_instr      <= mem_rdata;
            r_instrPc    <= w_memAddr;
            r_fetchCount <= r_fetchCount + 32'd1;
         end
      end
   end

   // Sticky fault. S_FAULT is terminal, so the first cause is the only one
   // ever written until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fault      <= 1'b0;
         r_faultCause <= FAULT_NONE;
      end else if (w_setFault && !r_fault) begin
         r_fault      <= 1'b1;
         r_faultCause <= w_faultCode;
      end
   end

   assign update_pc   = w_updatePc;
   assign mem_req     = w_memReq;
   assign mem_addr    = w_memAddr;
   assign instr       = r_instr;
   assign instr_pc    = r_instrPc;
   assign instr_valid = r_instrValid;
   assign fault       = r_fault;
   assign fault_cause = r_faultCause;
   assign fetch_count = r_fetchCount;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch. A behavioural model tracks the
// fetch sequence as "requesting / holding / faulted" with a count of unanswered
// request cycles, and a compare loop checks every DUT output against it on each
// falling edge. Directed scenarios add literal expectations, then randomized
// episodes vary ack rate, exec_done and PC alignment.
module tb_instruction_fetch;

   localparam int TIMEOUT = 4;

   logic        clk;
   logic        rst;
   logic [31:0] pcCurrent;
   logic        pcNextValid;
   logic        execDone;
   logic        updatePc;
   logic        memReq;
   logic [31:0] memAddr;
   logic        memAck;
   logic [31:0] memRdata;
   logic [31:0] instr;
   logic [31:0] instrPc;
   logic        instrValid;
   logic        fault;
   logic [1:0]  faultCause;
   logic [31:0] fetchCount;

   int assertCount = 0;
   int failCount   = 0;

   logic [31:0] pcResetVal;
   logic [31:0] pcNextVal;
   logic        sampledUpdate;

   bit          mStarted;
   bit          mRequesting;
   bit          mHolding;
   int          mUnanswered;
   bit          mFault;
   logic [1:0]  mCause;
   logic [31:0] mInstr;
   logic [31:0] mInstrPc;
   logic [31:0] mCount;

   instruction_fetch #(
      .DATA_WIDTH(32),
      .TIMEOUT_CYCLES(TIMEOUT),
      .CNT_WIDTH(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pc_current(pcCurrent),
      .pc_next_valid(pcNextValid),
      .exec_done(execDone),
      .update_pc(updatePc),
      .mem_req(memReq),
      .mem_addr(memAddr),
      .mem_ack(memAck),
      .mem_rdata(memRdata),
      .instr(instr),
      .instr_pc(instrPc),
      .instr_valid(instrValid),
      .fault(fault),
      .fault_cause(faultCause),
      .fetch_count(fetchCount)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural model plus the program counter environment. A request lasts
   // until acked; after 1+TIMEOUT unanswered request cycles it faults. A held
   // instruction is released by exec_done, either advancing the PC or faulting.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mStarted    = 1'b0;
         mRequesting = 1'b0;
         mHolding    = 1'b0;
         mUnanswered = 0;
         mFault      = 1'b0;
         mCause      = 2'b00;
         mInstr      = '0;
         mInstrPc    = '0;
         mCount      = '0;
         pcCurrent   = pcResetVal;
      end else begin
         if (!mStarted) begin
            mStarted    = 1'b1;
            mRequesting = 1'b1;
            mUnanswered = 0;
         end else if (mFault) begin
            mRequesting = 1'b0;
         end else if (mRequesting) begin
            if (memAck) begin
               mInstr      = memRdata;
               mInstrPc    = pcCurrent;
               mCount      = mCount + 32'd1;
               mRequesting = 1'b0;
               mHolding    = 1'b1;
            end else begin
               mUnanswered = mUnanswered + 1;
               if (mUnanswered == TIMEOUT + 1) begin
                  mFault      = 1'b1;
                  mCause      = 2'b10;
                  mRequesting = 1'b0;
               end
            end
         end else if (mHolding && execDone) begin
            mHolding = 1'b0;
            if (pcNextValid) begin
               mRequesting = 1'b1;
               mUnanswered = 0;
            end else begin
               mFault = 1'b1;
               mCause = 2'b01;
            end
         end
         if (sampledUpdate) begin
            pcCurrent = pcNextVal;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t",
                  name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                                input logic done, input logic nextValid);
      memAck      = ack;
      memRdata    = rdata;
      execDone    = done;
      pcNextValid = nextValid;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyReset();
      @(posedge clk);
      #1 rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Compare loop: checks every output against the model on each falling edge,
   // and records update_pc for the PC environment to act on at the next edge.
   task automatic compareLoop();
      logic expUpdate;
      forever begin
         @(negedge clk);
         expUpdate = mHolding && execDone && pcNextValid && !rst;
         checkOutput("mem_req",     {31'd0, memReq},     {31'd0, mRequesting});
         checkOutput("mem_addr",    memAddr,             mRequesting ? pcCurrent : 32'd0);
         checkOutput("update_pc",   {31'd0, updatePc},   {31'd0, expUpdate});
         checkOutput("instr_valid", {31'd0, instrValid}, {31'd0, mHolding});
         checkOutput("instr",       instr,               mInstr);
         checkOutput("instr_pc",    instrPc,             mInstrPc);
         checkOutput("fault",       {31'd0, fault},      {31'd0, mFault});
         checkOutput("fault_cause", {30'd0, faultCause}, {30'd0, mCause});
         checkOutput("fetch_count", fetchCount,          mCount);
         sampledUpdate = updatePc;
      end
   endtask

   initial begin
      int ackPct;
      int donePct;
      int alignPct;
      rst           = 1'b0;
      sampledUpdate = 1'b0;
      pcResetVal    = 32'h0;
      pcNextVal     = 32'h4;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      #1 rst = 1'b1;
      fork
         compareLoop();
      join_none

      // Zero-wait fetch from address 0, then a held instruction released later.
      applyStimulus(1'b1, 32'h00500093, 1'b0, 1'b1);
      applyReset();
      checkOutput("t1 reset fetch_count", fetchCount, 32'h0);
      tick();
      checkOutput("t1 req after start", {31'd0, memReq}, 32'd1);
      checkOutput("t1 addr", memAddr, 32'h0);
      checkOutput("t1 valid not yet", {31'd0, instrValid}, 32'd0);
      tick();
      checkOutput("t1 instr_valid", {31'd0, instrValid}, 32'd1);
      checkOutput("t1 instr", instr, 32'h00500093);
      checkOutput("t1 instr_pc", instrPc, 32'h0);
      checkOutput("t1 fetch_count", fetchCount, 32'd1);

      applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("t5 instr stable", instr, 32'h00500093);
         checkOutput("t5 no update", {31'd0, updatePc}, 32'd0);
      end
      checkOutput("t5 ack ignored", fetchCount, 32'd1);
      applyStimulus(1'b1, 32'h11111111, 1'b1, 1'b1);
      #1 checkOutput("t5 update pulse", {31'd0, updatePc}, 32'd1);
      tick();
      applyStimulus(1'b1, 32'h11111111, 1'b0, 1'b1);
      #1 checkOutput("t5 pulse ends", {31'd0, updatePc}, 32'd0);
      checkOutput("t5 new addr", memAddr, 32'h4);
      tick();
      checkOutput("t5 second instr_pc", instrPc, 32'h4);
      checkOutput("t5 second count", fetchCount, 32'd2);

      // Misaligned next PC: no update pulse, fault cause 01, stays halted.
      applyStimulus(1'b1, 32'h22222222, 1'b1, 1'b0);
      #1 checkOutput("t4 no update", {31'd0, updatePc}, 32'd0);
      tick();
      applyStimulus(1'b1, 32'h33333333, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("t4 fault", {31'd0, fault}, 32'd1);
         checkOutput("t4 cause", {30'd0, faultCause}, 32'd1);
         checkOutput("t4 halted req", {31'd0, memReq}, 32'd0);
         checkOutput("t4 halted update", {31'd0, updatePc}, 32'd0);
      end

      // Ack arrives on the fourth request cycle.
      pcResetVal = 32'h100;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      applyReset();
      tick();
      for (int i = 0; i < 4; i++) begin
         checkOutput("t2 req held", {31'd0, memReq}, 32'd1);
         checkOutput("t2 addr stable", memAddr, 32'h100);
         applyStimulus(i == 3, 32'hA0000000 | i, 1'b0, 1'b1);
         tick();
      end
      checkOutput("t2 req dropped", {31'd0, memReq}, 32'd0);
      checkOutput("t2 instr", instr, 32'hA0000003);
      checkOutput("t2 instr_pc", instrPc, 32'h100);

      // No ack at all: timeout after the request plus TIMEOUT wait cycles.
      pcResetVal = 32'h200;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      applyReset();
      tick();
      for (int i = 0; i < TIMEOUT + 1; i++) begin
         checkOutput("t3 no early fault", {31'd0, fault}, 32'd0);
         checkOutput("t3 req", {31'd0, memReq}, 32'd1);
         tick();
      end
      checkOutput("t3 fault", {31'd0, fault}, 32'd1);
      checkOutput("t3 cause", {30'd0, faultCause}, 32'd2);
      checkOutput("t3 req off", {31'd0, memReq}, 32'd0);

      // Asynchronous reset in the middle of a wait.
      pcResetVal = 32'h300;
      applyReset();
      tick();
      tick();
      checkOutput("t6 waiting", {31'd0, memReq}, 32'd1);
      #2 rst = 1'b1;
      #1;
      checkOutput("t6 req cleared", {31'd0, memReq}, 32'd0);
      checkOutput("t6 addr cleared", memAddr, 32'h0);
      checkOutput("t6 fault cleared", {31'd0, fault}, 32'd0);
      tick();
      rst = 1'b0;

      // Randomized episodes with varying memory latency and PC alignment.
      for (int ep = 0; ep < 40; ep++) begin
         case (ep % 4)
            0: ackPct = 100;
            1: ackPct = 60;
            2: ackPct = 30;
            default: ackPct = 10;
         endcase
         donePct    = $urandom_range(20, 80);
         alignPct   = (ep % 3 == 0) ? 90 : 99;
         pcResetVal = $urandom() & 32'hFFFF_FFFC;
         applyReset();
         for (int c = 0; c < 150; c++) begin
            pcNextVal = $urandom() & 32'hFFFF_FFFC;
            applyStimulus($urandom_range(0, 99) < ackPct, $urandom(),
                          $urandom_range(0, 99) < donePct,
                          $urandom_range(0, 99) < alignPct);
            tick();
         end
      end

      @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures",
               assertCount, failCount);
      $finish;
   end

endmodule
